// File: rtl/snes_pad_poller.sv
// snes_pad_poller: SNES pad latch/clock generator and report decoder; define SNES_DOUBLE_SAMPLE_EN to commit only on two matching frames
module snes_pad_poller #(
  parameter int DIV = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snes_data_in,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [15:0] buttons,
  output logic [15:0] pressed,
  output logic        valid,
  output logic        present
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int CW = $clog2(2 * DIV);
  localparam logic [TW-1:0] T_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);
  localparam logic [2:0] IDLE = 3'd0, LATCH = 3'd1, LOW = 3'd2, HIGH = 3'd3, COMMIT = 3'd4;
  logic [1:0] sync;
  logic [TW-1:0] timer;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [15:0] shift;
  logic [15:0] frame;
  logic done, ok;
`ifdef SNES_DOUBLE_SAMPLE_EN
  logic [15:0] prev;
  logic prev_ok;
`endif
  always_comb begin
    done = cnt == (state == LATCH ? LATCH_LAST : HALF_LAST);
    ok = shift[15:12] == 4'd0;
    frame = {4'd0, shift[11:0]};
  end
  // pad pins follow the state one cycle late, so the first latch rises on the 2nd edge after reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      timer <= '0;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      snes_latch <= 1'b0;
      snes_clk <= 1'b1;
      buttons <= '0;
      pressed <= '0;
      valid <= 1'b0;
      present <= 1'b0;
`ifdef SNES_DOUBLE_SAMPLE_EN
      prev <= '0;
      prev_ok <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], snes_data_in};
      timer <= timer == T_LAST ? '0 : timer + TW'(1);
      snes_latch <= state == LATCH;
      snes_clk <= state != LOW;
      valid <= 1'b0;
      pressed <= '0;
      cnt <= (state == IDLE || state == COMMIT || done) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: state <= timer == '0 ? LATCH : IDLE;
        LATCH: if (done) begin
          state <= LOW;
          idx <= '0;
        end
        LOW: if (done) begin
          shift[idx] <= ~sync[1];
          state <= HIGH;
        end
        HIGH: if (done) begin
          state <= idx == 4'd15 ? COMMIT : LOW;
          idx <= idx + 4'd1;
        end
        COMMIT: begin
          state <= IDLE;
          present <= ok;
          if (!ok) begin
            buttons <= '0;
`ifdef SNES_DOUBLE_SAMPLE_EN
            prev <= '0;
            prev_ok <= 1'b0;
`endif
          end else begin
`ifdef SNES_DOUBLE_SAMPLE_EN
            prev <= frame;
            prev_ok <= 1'b1;
            if (prev_ok && prev == frame) begin
              buttons <= frame;
              pressed <= frame & ~buttons;
              valid <= 1'b1;
            end
`else
            buttons <= frame;
            pressed <= frame & ~buttons;
            valid <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_snes_pad_poller.sv
// tb_snes_pad_poller: table-driven and randomized frames against a word-level model of the poller
module tb_snes_pad_poller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic snes_data_in;
  logic snes_latch, snes_clk, valid, present;
  logic [15:0] buttons, pressed;
  int total = 0;
  int bad = 0;

  snes_pad_poller #(.DIV(4), .POLL_PERIOD(200)) dut (
    .clk(clk), .reset(reset), .snes_data_in(snes_data_in),
    .snes_latch(snes_latch), .snes_clk(snes_clk), .buttons(buttons),
    .pressed(pressed), .valid(valid), .present(present)
  );

  always #5 clk = ~clk;

  // pad: bit n on the line after the nth shift-clock rise following latch
  logic [15:0] pad_raw = 16'hFFFF;
  logic [4:0] pad_n = 5'd16;
  always @(posedge snes_latch) pad_n = 5'd0;
  always @(posedge snes_clk) if (pad_n < 5'd16) pad_n = pad_n + 5'd1;
  assign snes_data_in = pad_n < 5'd16 ? pad_raw[pad_n[3:0]] : pad_raw[15];

  logic [15:0] m_b = '0;
  logic m_p = 1'b0;
  logic [15:0] m_prev = '0;
  logic m_prev_ok = 1'b0;

  typedef struct {
    logic [15:0] raw;
    logic [15:0] eb;
    logic [15:0] ep;
    logic ev;
    logic epres;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic model_reset();
    m_b = '0;
    m_p = 1'b0;
    m_prev = '0;
    m_prev_ok = 1'b0;
  endtask

  // entered on the negedge of cycle 1 (first cycle with latch high)
  task automatic measure(input logic [15:0] raw, output logic [15:0] ob, output logic [15:0] op,
                         output int vc, output logic opres);
    int hi = 0, lo = 0, rises = 0, vcyc = 0, stray = 0;
    logic prev_sclk = snes_clk;
    logic [15:0] f, ep;
    logic ev;
    vc = 0;
    op = '0;
    for (int k = 1; k <= 145; k++) begin
      if (snes_latch) hi++;
      if (!snes_clk) lo++;
      if (snes_clk && !prev_sclk) rises++;
      prev_sclk = snes_clk;
      if (valid) begin
        vc++;
        vcyc = k;
        op = pressed;
      end else if (pressed != 0) stray++;
      if (k < 145) @(negedge clk);
    end
    ob = buttons;
    opres = present;
    f = ~raw;
    ev = 1'b0;
    ep = '0;
    if (f[15:12] != 4'd0) begin
      model_reset();
    end else begin
      m_p = 1'b1;
`ifdef SNES_DOUBLE_SAMPLE_EN
      if (m_prev_ok && m_prev == f) begin
        ev = 1'b1;
        ep = f & ~m_b;
        m_b = f;
      end
      m_prev = f;
      m_prev_ok = 1'b1;
`else
      ev = 1'b1;
      ep = f & ~m_b;
      m_b = f;
`endif
    end
    chk("latch_len", hi, 8);
    chk("sclk_low", lo, 64);
    chk("sclk_rises", rises, 16);
    chk("valid_count", vc, ev ? 1 : 0);
    chk("valid_cycle", vcyc, ev ? 137 : 0);
    chk("pressed", op, ep);
    chk("pressed_stray", stray, 0);
    chk("buttons", ob, m_b);
    chk("present", opres, m_p);
  endtask

  task automatic do_frame(input logic [15:0] raw, output logic [15:0] ob, output logic [15:0] op,
                          output int vc, output logic opres);
    pad_raw = raw;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (snes_latch) break;
    end
    chk("latch_start", snes_latch, 1);
    ob = '0; op = '0; vc = -1; opres = 1'bx;
    if (snes_latch) measure(raw, ob, op, vc, opres);
  endtask

  task automatic start_after_reset(input logic [15:0] raw);
    logic [15:0] ob, op;
    int vc;
    logic opres;
    pad_raw = raw;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("latch_edge1", snes_latch, 0);
    @(negedge clk);
    chk("latch_edge2", snes_latch, 1);
    if (snes_latch) measure(raw, ob, op, vc, opres);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ob, op, raw, last;
    int vc, quiet;
    logic opres;
`ifdef SNES_DOUBLE_SAMPLE_EN
    tbl[0] = '{16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[1] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b1};
    tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b1};
    tbl[7] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1};
`else
    tbl[0] = '{16'hFEF7, 16'h0108, 16'h0108, 1'b1, 1'b1};
    tbl[1] = '{16'hFEF7, 16'h0108, 16'h0000, 1'b1, 1'b1};
    tbl[2] = '{16'hFFF7, 16'h0008, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'hFEF7, 16'h0108, 16'h0108, 1'b1, 1'b1};
    tbl[7] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
`endif
    #2 reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_latch", snes_latch, 0);
    chk("rst_sclk", snes_clk, 1);
    chk("rst_buttons", buttons, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_valid", valid, 0);
    chk("rst_present", present, 0);
    model_reset();
    start_after_reset(16'hFFFF);

    for (int i = 0; i < 8; i++) begin
      do_frame(tbl[i].raw, ob, op, vc, opres);
      chk($sformatf("tbl%0d_buttons", i), ob, tbl[i].eb);
      chk($sformatf("tbl%0d_pressed", i), op, tbl[i].ep);
      chk($sformatf("tbl%0d_valid", i), vc, tbl[i].ev ? 1 : 0);
      chk($sformatf("tbl%0d_present", i), opres, tbl[i].epres);
    end

    pad_raw = 16'hFEF7;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (snes_latch) break;
    end
    chk("mid_latch_start", snes_latch, 1);
    repeat (41) @(negedge clk);
    chk("mid_in_low5", snes_clk, 0);
    reset = 1'b1;
    #1;
    chk("mid_latch", snes_latch, 0);
    chk("mid_sclk", snes_clk, 1);
    chk("mid_valid", valid, 0);
    chk("mid_buttons", buttons, 0);
    chk("mid_present", present, 0);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid || snes_latch || !snes_clk) quiet++;
    end
    chk("mid_quiet", quiet, 0);
    model_reset();
    start_after_reset(16'hFFFF);

    last = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      int r = $urandom_range(0, 9);
      raw = r == 0 ? 16'h0000 : r == 1 ? 16'($urandom) : r < 5 ? last : {4'hF, 12'($urandom)};
      last = raw;
      do_frame(raw, ob, op, vc, opres);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snes_pad_poller.md
# snes_pad_poller

Self-timed SNES gamepad poller that sits between a controller port and the CPU's controller input. It generates the pad's latch and clock waveforms from the system clock, shifts in the 16-bit serial report through a synchronizer, and checks that a pad is present. It publishes an active-high button word plus per-poll press edges and a one-cycle update strobe. One instance is used per controller port.

## Interface

**Parameters**
- `DIV`, default 300: system-clock cycles per SNES half-bit, 6 µs at 50 MHz. Must be ≥ 4.
- `POLL_PERIOD`, default 833333: cycles between poll starts, about 60 Hz at 50 MHz. Must be ≥ 34*DIV + 4.

**Ports**
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `snes_data_in`, in, 1: serial data from the pad. Active-low, asynchronous to `clk`.
- `snes_latch`, out, 1: latch pulse to the pad.
- `snes_clk`, out, 1: shift clock to the pad. Idles high.
- `buttons`, out, 16: debounced state, 1 = pressed. Bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12–15 always 0.
- `pressed`, out, 16: rising-edge mask, `new & ~old`. Valid only in the `valid` cycle, 0 otherwise.
- `valid`, out, 1: one-cycle strobe when an accepted frame is committed.
- `present`, out, 1: 1 if the last completed frame passed the presence check.

## Operation

- `snes_data_in` passes through a 2-flop synchronizer. All sampling uses the synchronized value, inverted so that 1 = pressed.
- A poll timer free-runs from 0 to POLL_PERIOD-1 and wraps. When the timer is 0 and the FSM is in IDLE, a frame starts.
- FSM states:
  - **IDLE**: `snes_latch` = 0, `snes_clk` = 1. Exits to LATCH when the timer is 0.
  - **LATCH**: `snes_latch` = 1 for 2*DIV cycles. Exits to LOW with bit index 0.
  - **LOW**: `snes_clk` = 0 for DIV cycles. On the last cycle, the inverted synchronized bit is written to `shift[idx]`. Exits to HIGH.
  - **HIGH**: `snes_clk` = 1 for DIV cycles. If idx = 15, exits to COMMIT; otherwise idx++ and back to LOW.
  - **COMMIT**: one cycle, then IDLE.
- Presence check in COMMIT: `shift[15:12]` must be 0, which is true for a real pad.
  - Pass: `present` ← 1, `pressed` ← `{4'b0, shift[11:0]} & ~buttons`, `buttons` ← `{4'b0, shift[11:0]}`, `valid` ← 1.
  - Fail (no pad, or the line is stuck low): `present` ← 0, `buttons` ← 0, `pressed` ← 0, `valid` stays 0.
- Outputs are registered. `pressed` and `valid` return to 0 on the cycle after COMMIT.
- A new poll never overlaps a frame, because the timer is only acted on in IDLE.

## Timing

- Reset values (asynchronous): `snes_latch` 0, `snes_clk` 1, `buttons` 0, `pressed` 0, `valid` 0, `present` 0. Timer, FSM, idx, shift register and synchronizer are all cleared.
- The first `snes_latch` rise is on the 2nd `clk` edge after `reset` deasserts.
- Frame length, latch rise to `valid`: 2*DIV + 32*DIV cycles, with `valid` asserted on cycle 34*DIV + 1.
- `snes_latch` high for exactly 2*DIV cycles, followed by 16 low/high clock pairs of DIV cycles each.
- `snes_clk` rises 16 times per frame. The final rise returns the line to idle.
- Reset asserted mid-frame aborts the frame immediately; outputs take their reset values and no `valid` is produced.
- An identical report commits with `valid` = 1 and `pressed` = 0.
- A release clears the `buttons` bit and produces no `pressed` bit.

## Configuration

- `SNES_DOUBLE_SAMPLE_EN` defined:
  - Every frame that passes the presence check is held as a candidate.
  - `buttons` and `pressed` update only when the candidate equals the previous passing frame.
  - `valid` pulses only on such matching commits.
  - A failed frame clears both the candidate and the previous-frame record.
  - A first press therefore appears after two polls.
- Not defined: every passing frame commits immediately, as described in Operation.

## Test plan

All scenarios use DIV=4, POLL_PERIOD=200, and a pad model that drives bit n after the nth `snes_clk` rise following the latch.

- **Reset and first frame.** Release reset. Required: latch rises on the 2nd edge and stays high 8 cycles; 16 `snes_clk` low pulses of 4 cycles each; `valid` on cycle 137 after latch rise; pad idle gives `buttons` = 0x0000 and `present` = 1.
- **Press pattern.** Pad reports A+Start, raw line pattern 0xFEF7 (active-low). Required: `buttons` = 0x0108, `pressed` = 0x0108 for 1 cycle. The next identical poll gives `pressed` = 0 with `valid` = 1.
- **Release edge.** Pad goes from 0x0108 to 0x0008. Required: `buttons` = 0x0008 and `pressed` = 0.
- **No pad.** Data line held low. Required: `present` = 0, `buttons` = 0, no `valid`. Reconnecting an idle pad restores `present` = 1 on the next poll.
- **Mid-frame reset.** Assert reset during the 5th LOW phase. Required: `snes_latch` = 0 and `snes_clk` = 1 immediately, no `valid`, and a clean new frame after release.
- **With SNES_DOUBLE_SAMPLE_EN.** A 0x0001 report on one poll, then 0x0000, then 0x0001 twice. Required: `buttons` changes only after the second consecutive 0x0001.
